layer_buffer: RTL and testbench

Parametrised true dual-port local buffer for layer feature data, the next generation of the fixed 912×128 layer SRAM wrapper. It adds resolution of same-address collisions by forwarding and lane-level priority instead of address aliasing, per-lane write masks, read-valid outputs, out-of-range detection and a self-clearing init sweep. It sits between the convolution engine, on port A, and the layer loader/drainer, on port B, inside LocalBuffer.

---
 rtl/layer_buffer.sv | 146 ++++++++++++++
 tb/tb_layer_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/layer_buffer.sv
// layer_buffer: true dual-port local feature buffer with per-lane write masks,
// same-address forwarding and lane priority, out-of-range detection, a
// saturating write-write collision counter and a self-clearing init sweep.
// Port A serves the convolution engine, port B the layer loader/drainer.
module layer_buffer #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned LANES  = 8,
   parameter int unsigned DEPTH  = 912,
   parameter int unsigned AW     = 10,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              CK,
   input  logic              rst,
   input  logic              init_start,
   output logic              init_busy,
   output logic              init_done,
   input  logic              CSA,
   input  logic              CSB,
   input  logic              WEAN,
   input  logic              WEBN,
   input  logic [AW-1:0]     A,
   input  logic [AW-1:0]     B,
   input  logic [LANES-1:0]  MA,
   input  logic [LANES-1:0]  MB,
   input  logic [DATA_W-1:0] DIA,
   input  logic [DATA_W-1:0] DIB,
   output logic [DATA_W-1:0] DOA,
   output logic [DATA_W-1:0] DOB,
   output logic              VA,
   output logic              VB,
   output logic              oor_err,
   output logic [CNT_W-1:0]  coll_cnt
);

   localparam int unsigned LW = DATA_W / LANES;

   typedef enum logic [0:0] {StIdle, StInit} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   ptr_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              a_act, b_act, a_rd, b_rd, a_wr, b_wr;
   logic              a_ok, b_ok, same, coll, start;
   logic [LANES-1:0]  wa_lanes, wb_lanes;
   logic [DATA_W-1:0] wa_bits, wb_bits;
   logic [DATA_W-1:0] mem_a, mem_b, merged, rda, rdb;

   // Sweep FSM next state and the busy flag.
   always_comb begin
      state_d   = state_q;
      init_busy = 1'b0;
      unique case (state_q)
         StIdle: if (init_start) state_d = StInit;
         StInit: begin
            init_busy = 1'b1;
            if (ptr_q == AW'(DEPTH - 1)) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Sweep state, pointer and the completion pulse.
   always_ff @(posedge CK) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         init_done <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_done <= (state_q == StInit) && (state_d == StIdle);
         if (state_q == StInit) ptr_q <= ptr_q + AW'(1);
         else                   ptr_q <= '0;
      end
   end

   // Port decode, lane priority and same-address forwarding.
   always_comb begin
      start = (state_q == StIdle) && init_start;
      a_act = (state_q == StIdle) && CSA;
      b_act = (state_q == StIdle) && CSB;
      a_rd  = a_act && WEAN;
      b_rd  = b_act && WEBN;
      a_wr  = a_act && !WEAN;
      b_wr  = b_act && !WEBN;
      a_ok  = 32'(A) < DEPTH;
      b_ok  = 32'(B) < DEPTH;
      same  = a_act && b_act && a_ok && b_ok && (A == B);
      coll  = same && a_wr && b_wr && (|(MA & MB));
      wa_lanes = (a_wr && a_ok) ? MA : '0;
      // On a shared address, A owns every lane it writes.
      wb_lanes = (b_wr && b_ok) ? (MB & ~(same ? wa_lanes : '0)) : '0;
      wa_bits = '0;
      wb_bits = '0;
      for (int i = 0; i < LANES; i++) begin
         wa_bits[i*LW +: LW] = {LW{wa_lanes[i]}};
         wb_bits[i*LW +: LW] = {LW{wb_lanes[i]}};
      end
      mem_a  = mem[A];
      mem_b  = mem[B];
      // Write-first view of the shared word; equals mem_a when nobody writes.
      merged = (mem_a & ~(wa_bits | wb_bits)) | (DIA & wa_bits) | (DIB & wb_bits);
      rda    = same ? merged : mem_a;
      rdb    = same ? merged : mem_b;
   end

   // Memory array; contents survive rst, only the sweep clears them.
   always_ff @(posedge CK) begin
      if (!rst) begin
         if (state_q == StInit) begin
            mem[ptr_q] <= '0;
         end else begin
            for (int i = 0; i < LANES; i++) begin
               if (wa_lanes[i]) mem[A][i*LW +: LW] <= DIA[i*LW +: LW];
               if (wb_lanes[i]) mem[B][i*LW +: LW] <= DIB[i*LW +: LW];
            end
         end
      end
   end

   // Registered read data, valid pulses and status flags.
   always_ff @(posedge CK) begin
      if (rst) begin
         DOA      <= '0;
         DOB      <= '0;
         VA       <= 1'b0;
         VB       <= 1'b0;
         oor_err  <= 1'b0;
         coll_cnt <= '0;
      end else begin
         VA <= a_rd;
         VB <= b_rd;
         if (a_rd) DOA <= a_ok ? rda : '0;
         if (b_rd) DOB <= b_ok ? rdb : '0;
         if (start) begin
            oor_err  <= 1'b0;
            coll_cnt <= '0;
         end else begin
            if ((a_act && !a_ok) || (b_act && !b_ok)) oor_err <= 1'b1;
            if (coll && (coll_cnt != '1)) coll_cnt <= coll_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_layer_buffer.sv
// Directed bench for layer_buffer: expected read words are queued when a read
// is issued and popped when the valid pulse is due one cycle later.
module tb_layer_buffer;

   localparam int unsigned DATA_W = 128;
   localparam int unsigned LANES  = 8;
   localparam int unsigned DEPTH  = 912;
   localparam int unsigned AW     = 10;
   localparam int unsigned CNT_W  = 4;  // small so saturation is reachable quickly

   logic              CK = 1'b0;
   logic              rst, init_start, init_busy, init_done;
   logic              CSA, CSB, WEAN, WEBN, VA, VB, oor_err;
   logic [AW-1:0]     A, B;
   logic [LANES-1:0]  MA, MB;
   logic [DATA_W-1:0] DIA, DIB, DOA, DOB;
   logic [CNT_W-1:0]  coll_cnt;

   int passed = 0;
   int total  = 0;
   int failed = 0;
   int bc, dc, di, vc;

   logic [127:0] qa[$];
   logic [127:0] qb[$];

   localparam logic [127:0] P    = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] Q    = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
   localparam logic [127:0] ONES = {128{1'b1}};

   layer_buffer #(
      .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)
   ) dut (
      .CK(CK), .rst(rst), .init_start(init_start), .init_busy(init_busy),
      .init_done(init_done), .CSA(CSA), .CSB(CSB), .WEAN(WEAN), .WEBN(WEBN),
      .A(A), .B(B), .MA(MA), .MB(MB), .DIA(DIA), .DIB(DIB), .DOA(DOA), .DOB(DOB),
      .VA(VA), .VB(VB), .oor_err(oor_err), .coll_cnt(coll_cnt)
   );

   always #5 CK = ~CK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      CSA = 1'b0; CSB = 1'b0; WEAN = 1'b1; WEBN = 1'b1; init_start = 1'b0;
   endtask

   // One clock: check valid pulses and pop expected words, then release ports.
   task automatic step();
      @(posedge CK); #1;
      chk("VA", 128'(VA), 128'(qa.size() != 0));
      if (qa.size() != 0) chk("DOA", DOA, qa.pop_front());
      chk("VB", 128'(VB), 128'(qb.size() != 0));
      if (qb.size() != 0) chk("DOB", DOB, qb.pop_front());
      idle();
   endtask

   task automatic rd_a(input logic [AW-1:0] ad, input logic [127:0] exp);
      CSA = 1'b1; WEAN = 1'b1; A = ad; qa.push_back(exp);
   endtask

   task automatic rd_b(input logic [AW-1:0] ad, input logic [127:0] exp);
      CSB = 1'b1; WEBN = 1'b1; B = ad; qb.push_back(exp);
   endtask

   task automatic wr_a(input logic [AW-1:0] ad, input logic [7:0] m, input logic [127:0] d);
      CSA = 1'b1; WEAN = 1'b0; A = ad; MA = m; DIA = d;
   endtask

   task automatic wr_b(input logic [AW-1:0] ad, input logic [7:0] m, input logic [127:0] d);
      CSB = 1'b1; WEBN = 1'b0; B = ad; MB = m; DIB = d;
   endtask

   initial begin
      idle();
      A = '0; B = '0; MA = '0; MB = '0; DIA = '0; DIB = '0;
      rst = 1'b1;
      repeat (2) @(posedge CK);
      #1;
      rst = 1'b0;
      chk("rst_doa", DOA, 128'h0);
      chk("rst_dob", DOB, 128'h0);
      chk("rst_va", 128'(VA), 128'h0);
      chk("rst_vb", 128'(VB), 128'h0);
      chk("rst_busy", 128'(init_busy), 128'h0);
      chk("rst_done", 128'(init_done), 128'h0);
      chk("rst_oor", 128'(oor_err), 128'h0);
      chk("rst_coll", 128'(coll_cnt), 128'h0);

      // Full sweep; port traffic and a second init_start during it are ignored.
      init_start = 1'b1;
      bc = 0; dc = 0; di = -1; vc = 0;
      for (int i = 0; i < 920; i++) begin
         @(posedge CK); #1;
         init_start = (i == 5);
         if (i == 0) begin
            CSA = 1'b1; WEAN = 1'b1; A = 5;
            CSB = 1'b1; WEBN = 1'b0; B = 6; MB = '1; DIB = ONES;
         end
         if (i == 900) idle();
         if (init_busy) bc++;
         if (init_done) begin dc++; di = i; end
         if (VA || VB) vc++;
      end
      chk("busy_cycles", 128'(bc), 128'(DEPTH));
      chk("done_pulses", 128'(dc), 128'h1);
      chk("done_cycle", 128'(di), 128'(DEPTH));
      chk("valid_in_init", 128'(vc), 128'h0);

      rd_a(0, 128'h0);   rd_b(455, 128'h0); step();
      rd_a(911, 128'h0); rd_b(6, 128'h0);   step();
      step();

      // Write then read on the other port.
      wr_a(5, 8'hFF, P); step();
      rd_b(5, P); step();
      step();

      // Write-first forwarding on a same-address A write / B read.
      wr_a(7, 8'hFF, ONES); step();
      wr_a(7, 8'h0F, 128'h0); rd_b(7, {64'hFFFFFFFFFFFFFFFF, 64'h0}); step();
      rd_a(7, {64'hFFFFFFFFFFFFFFFF, 64'h0}); step();

      // Write-write collisions: A wins shared lanes, B keeps the rest.
      wr_a(9, 8'hFF, {16{8'h11}}); step();
      wr_a(9, 8'h03, {16{8'hAA}}); wr_b(9, 8'h06, {16{8'h55}}); step();
      chk("coll_one", 128'(coll_cnt), 128'h1);
      rd_a(9, {80'h11111111111111111111, 16'h5555, 32'hAAAAAAAA}); step();
      wr_a(9, 8'h01, {16{8'hAA}}); wr_b(9, 8'h02, {16{8'h55}}); step();
      chk("coll_disjoint", 128'(coll_cnt), 128'h1);
      rd_b(9, {80'h11111111111111111111, 16'h5555, 16'h5555, 16'hAAAA}); step();
      for (int i = 0; i < 20; i++) begin
         wr_a(9, 8'h01, {16{8'hAA}}); wr_b(9, 8'h01, {16{8'h55}}); step();
      end
      chk("coll_sat", 128'(coll_cnt), 128'hF);

      // Out-of-range accesses.
      rd_a(912, 128'h0); step();
      chk("oor_set", 128'(oor_err), 128'h1);
      wr_b(1000, 8'hFF, ONES); step();
      rd_a(88, 128'h0); rd_b(911, 128'h0); step();
      chk("oor_sticky", 128'(oor_err), 128'h1);

      // Reset in the middle of a sweep.
      wr_a(50, 8'hFF, P); wr_b(200, 8'hFF, Q); step();
      init_start = 1'b1;
      @(posedge CK); #1;
      init_start = 1'b0;
      repeat (100) @(posedge CK);
      #1;
      chk("busy_mid", 128'(init_busy), 128'h1);
      rst = 1'b1;
      @(posedge CK); #1;
      rst = 1'b0;
      chk("abort_busy", 128'(init_busy), 128'h0);
      chk("abort_done", 128'(init_done), 128'h0);
      step();
      chk("abort_done2", 128'(init_done), 128'h0);
      chk("abort_oor", 128'(oor_err), 128'h0);
      chk("abort_coll", 128'(coll_cnt), 128'h0);
      rd_a(50, 128'h0); rd_b(200, Q); step();
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
